// File: rtl/idu_pipe_if.sv
// Handshake and decoded-bundle bus between IFU, the decode stage and the EXU.
// master = surrounding pipeline (drives fetch side, consumes decode); slave = idu_pipe.
interface idu_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rwen;
  logic        out_mem_ren;
  logic        out_mem_wen;
  logic [1:0]  out_size;
  logic        out_sext;
  logic [7:0]  out_alu_op;
  logic [3:0]  out_md_op;
  logic        out_ecall;
  logic        out_mret;
  logic        out_halt;
  logic        out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_rwen, out_mem_ren, out_mem_wen, out_size, out_sext,
           out_alu_op, out_md_op, out_ecall, out_mret, out_halt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_rwen, out_mem_ren, out_mem_wen, out_size, out_sext,
           out_alu_op, out_md_op, out_ecall, out_mret, out_halt, out_illegal
  );
endinterface

// File: rtl/idu_pipe.sv
// RV32I(+M) decode stage: one instruction/cycle, decoded bundle registered 1 cycle after accept.
// Two-entry skid (A presented, B spare) absorbs EXU stalls; in_ready derives from state only.
module idu_pipe #(
  parameter bit M_EXT = 1'b0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  idu_pipe_if.slave        bus,
  output logic [CNT_W-1:0] decode_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rwen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  size;
    logic        sext;
    logic [7:0]  alu_op;
    logic [3:0]  md_op;
    logic        ecall;
    logic        mret;
    logic        halt;
    logic        illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [7:0] ALU_SUB  = 8'h01;
  localparam logic [7:0] ALU_XOR  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_AND  = 8'h08;
  localparam logic [7:0] ALU_SLL  = 8'h10;
  localparam logic [7:0] ALU_SRL  = 8'h20;
  localparam logic [7:0] ALU_SRA  = 8'h40;
  localparam logic [7:0] ALU_CSRC = 8'h80;

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t        dec;
  logic        bad;

  assign inst  = bus.in_inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.pc  = bus.in_pc;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    case (opc)
      OPC_LUI: begin
        dec.imm  = imm_u;
        dec.rs1  = '0;
        dec.rwen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm  = imm_u;
        dec.rwen = 1'b1;
      end
      OPC_JAL: begin
        dec.imm  = imm_j;
        dec.rwen = 1'b1;
      end
      OPC_JALR: begin
        dec.imm  = imm_i;
        dec.rwen = 1'b1;
        bad      = (f3 != 3'b000);
      end
      // Branches carry the compare bit plus the condition-specific bit.
      OPC_BRANCH: begin
        dec.imm = imm_b;
        case (f3)
          3'b000:  dec.alu_op = ALU_SUB | ALU_XOR;
          3'b001:  dec.alu_op = ALU_SUB | ALU_OR;
          3'b100:  dec.alu_op = ALU_SUB | ALU_SRL;
          3'b101:  dec.alu_op = ALU_SUB | ALU_SRA;
          3'b110:  dec.alu_op = ALU_SUB | ALU_AND;
          3'b111:  dec.alu_op = ALU_SUB | ALU_SLL;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm     = imm_i;
        dec.rwen    = 1'b1;
        dec.mem_ren = 1'b1;
        case (f3)
          3'b000:  begin dec.size = 2'b00; dec.sext = 1'b1; end
          3'b001:  begin dec.size = 2'b01; dec.sext = 1'b1; end
          3'b010:  dec.size = 2'b10;
          3'b100:  dec.size = 2'b00;
          3'b101:  dec.size = 2'b01;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm     = imm_s;
        dec.mem_wen = 1'b1;
        case (f3)
          3'b000:  dec.size = 2'b00;
          3'b001:  dec.size = 2'b01;
          3'b010:  dec.size = 2'b10;
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.imm  = imm_i;
        dec.rwen = 1'b1;
        case (f3)
          3'b000: dec.alu_op = '0;
          3'b010: dec.alu_op = ALU_SUB | ALU_SRL;
          3'b011: dec.alu_op = ALU_SUB | ALU_AND;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            bad        = (f7 != 7'b0000000);
          end
          default: begin
            if (f7 == 7'b0000000)      dec.alu_op = ALU_SRL;
            else if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.rwen = 1'b1;
        if (f7 == 7'b0000001) begin
          if (M_EXT) dec.md_op = {1'b1, f3};
          else       bad = 1'b1;
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alu_op = '0;
            3'b001:  dec.alu_op = ALU_SLL;
            3'b010:  dec.alu_op = ALU_SUB | ALU_SRL;
            3'b011:  dec.alu_op = ALU_SUB | ALU_AND;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = ALU_SRL;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        dec.imm = imm_i;
        case (f3)
          3'b000: begin
            case (inst)
              32'h0000_0073: dec.ecall = 1'b1;
              32'h0010_0073: dec.halt  = 1'b1;
              32'h3020_0073: dec.mret  = 1'b1;
              default:       bad       = 1'b1;
            endcase
          end
          3'b001: begin
            dec.rwen = 1'b1;
            dec.rs2  = '0;
          end
          3'b010: begin
            dec.rwen   = 1'b1;
            dec.alu_op = ALU_OR;
          end
          3'b011: begin
            dec.rwen   = 1'b1;
            dec.alu_op = ALU_CSRC;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) bad = 1'b1;
    // Illegal instructions must not cause any architectural side effect downstream.
    if (bad) begin
      dec.rwen    = 1'b0;
      dec.mem_ren = 1'b0;
      dec.mem_wen = 1'b0;
      dec.halt    = 1'b0;
      dec.ecall   = 1'b0;
      dec.mret    = 1'b0;
      dec.md_op   = '0;
    end
    dec.illegal = bad;
  end

  state_t state, state_nxt;
  logic   in_rdy, out_vld, take, load_a, load_b, move_b;
  dec_t   ent_a, ent_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (bus.in_valid) state_nxt = ONE;
      ONE: begin
        if (bus.in_valid && !bus.out_ready)      state_nxt = FULL;
        else if (!bus.in_valid && bus.out_ready) state_nxt = EMPTY;
      end
      FULL:    if (bus.out_ready) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Everything here is a function of the registered state and the peers' inputs,
  // so in_ready never depends combinationally on out_ready.
  always_comb begin
    in_rdy  = (state != FULL);
    out_vld = (state != EMPTY);
    take    = (state != EMPTY) && bus.out_ready;
    load_a  = bus.in_valid && ((state == EMPTY) || (state == ONE && bus.out_ready));
    load_b  = bus.in_valid && (state == ONE) && !bus.out_ready;
    move_b  = (state == FULL) && bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_a <= '0;
      ent_b <= '0;
    end else begin
      if (load_a)      ent_a <= dec;
      else if (move_b) ent_a <= ent_b;
      if (load_b)      ent_b <= dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    decode_cnt <= '0;
    else if (take) decode_cnt <= decode_cnt + CNT_W'(1);
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld;
  assign bus.out_pc      = ent_a.pc;
  assign bus.out_imm     = ent_a.imm;
  assign bus.out_rs1     = ent_a.rs1;
  assign bus.out_rs2     = ent_a.rs2;
  assign bus.out_rd      = ent_a.rd;
  assign bus.out_rwen    = ent_a.rwen;
  assign bus.out_mem_ren = ent_a.mem_ren;
  assign bus.out_mem_wen = ent_a.mem_wen;
  assign bus.out_size    = ent_a.size;
  assign bus.out_sext    = ent_a.sext;
  assign bus.out_alu_op  = ent_a.alu_op;
  assign bus.out_md_op   = ent_a.md_op;
  assign bus.out_ecall   = ent_a.ecall;
  assign bus.out_mret    = ent_a.mret;
  assign bus.out_halt    = ent_a.halt;
  assign bus.out_illegal = ent_a.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench: two decoders share stimulus; dut_a has RV32M and a 4-bit counter,
// dut_b has no RV32M and a 32-bit counter.
module tb_idu_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  idu_pipe_if ifa ();
  idu_pipe_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_inst   = in_inst;
  assign ifa.in_pc     = in_pc;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_inst   = in_inst;
  assign ifb.in_pc     = in_pc;
  assign ifb.out_ready = out_ready;

  idu_pipe #(.M_EXT(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa), .decode_cnt(cnt_a)
  );
  idu_pipe #(.M_EXT(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb), .decode_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Presents one instruction with the sink ready; returns at the negedge where it is on the outputs.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_in_ready",  32'(ifa.in_ready),  32'd1);
    chk("rst_cnt",       cnt_b,              32'd0);
    chk("rst_pc",        ifa.out_pc,         32'd0);
    chk("rst_alu_op",    32'(ifa.out_alu_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h0050_0093, 32'h0000_1000);             // ADDI x1,x0,5
    chk("addi_valid", 32'(ifa.out_valid), 32'd1);
    chk("addi_pc",    ifa.out_pc,          32'h1000);
    chk("addi_rd",    32'(ifa.out_rd),     32'd1);
    chk("addi_rs1",   32'(ifa.out_rs1),    32'd0);
    chk("addi_imm",   ifa.out_imm,         32'd5);
    chk("addi_rwen",  32'(ifa.out_rwen),   32'd1);
    chk("addi_alu",   32'(ifa.out_alu_op), 32'd0);
    chk("addi_ill",   32'(ifa.out_illegal), 32'd0);
    @(negedge clk);
    chk("addi_cnt",   cnt_b,               32'd1);
    chk("addi_drain", 32'(ifa.out_valid),  32'd0);

    send(32'h0020_A423, 32'h0000_1004);             // SW x2,8(x1)
    chk("sw_wen",  32'(ifa.out_mem_wen), 32'd1);
    chk("sw_imm",  ifa.out_imm,          32'd8);
    chk("sw_size", 32'(ifa.out_size),    32'd2);
    chk("sw_rwen", 32'(ifa.out_rwen),    32'd0);
    chk("sw_rs2",  32'(ifa.out_rs2),     32'd2);

    send(32'hFFC0_8283, 32'h0000_1008);             // LB x5,-4(x1)
    chk("lb_pc",   ifa.out_pc,           32'h1008);
    chk("lb_size", 32'(ifa.out_size),    32'd0);
    chk("lb_sext", 32'(ifa.out_sext),    32'd1);
    chk("lb_ren",  32'(ifa.out_mem_ren), 32'd1);
    chk("lb_imm",  ifa.out_imm,          32'hFFFF_FFFC);

    send(32'h1234_53B7, 32'h0000_100C);             // LUI x7,0x12345
    chk("lui_rs1", 32'(ifa.out_rs1), 32'd0);
    chk("lui_imm", ifa.out_imm,      32'h1234_5000);
    chk("lui_rd",  32'(ifa.out_rd),  32'd7);

    send(32'h0220_81B3, 32'h0000_1010);             // MUL x3,x1,x2
    chk("mul_md_a",   32'(ifa.out_md_op),   32'h8);
    chk("mul_rd_a",   32'(ifa.out_rd),      32'd3);
    chk("mul_ill_a",  32'(ifa.out_illegal), 32'd0);
    chk("mul_ill_b",  32'(ifb.out_illegal), 32'd1);
    chk("mul_rwen_b", 32'(ifb.out_rwen),    32'd0);
    chk("mul_md_b",   32'(ifb.out_md_op),   32'd0);

    send(32'h4020_81B3, 32'h0000_1014);             // SUB x3,x1,x2
    chk("sub_alu", 32'(ifa.out_alu_op), 32'h01);
    chk("sub_imm", ifa.out_imm,         32'd0);

    send(32'h0010_0073, 32'h0000_1018);             // EBREAK
    chk("ebreak_halt", 32'(ifa.out_halt),    32'd1);
    chk("ebreak_ill",  32'(ifa.out_illegal), 32'd0);
    send(32'h0000_0073, 32'h0000_101C);             // ECALL
    chk("ecall",       32'(ifa.out_ecall),   32'd1);
    send(32'h3020_0073, 32'h0000_1020);             // MRET
    chk("mret",        32'(ifa.out_mret),    32'd1);
    send(32'h0000_0000, 32'h0000_1024);
    chk("zero_ill",    32'(ifa.out_illegal), 32'd1);
    chk("zero_rwen",   32'(ifa.out_rwen),    32'd0);
    chk("zero_pc",     ifa.out_pc,           32'h1024);
    @(negedge clk);
    chk("cnt_10", cnt_b, 32'd10);

    // Four instructions while the sink stalls for three edges.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h2000;
    @(negedge clk);
    chk("st_rdy_one", 32'(ifa.in_ready), 32'd1);
    chk("st_pc0",     ifa.out_pc,        32'h2000);
    in_pc = 32'h2004;
    @(negedge clk);
    chk("st_rdy_full", 32'(ifa.in_ready), 32'd0);
    chk("st_pc0_hold", ifa.out_pc,        32'h2000);
    in_pc = 32'h2008;
    @(negedge clk);
    chk("st_rdy_full2", 32'(ifa.in_ready), 32'd0);
    chk("st_pc0_hold2", ifa.out_pc,        32'h2000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("st_pc1",     ifa.out_pc,        32'h2004);
    chk("st_rdy_ret", 32'(ifa.in_ready), 32'd1);
    @(negedge clk);
    chk("st_pc2", ifa.out_pc, 32'h2008);
    in_pc = 32'h200C;
    @(negedge clk);
    chk("st_pc3", ifa.out_pc, 32'h200C);
    in_valid = 1'b0;
    @(negedge clk);
    chk("st_empty", 32'(ifa.out_valid), 32'd0);
    chk("st_cnt",   cnt_b,              32'd14);

    // Fill both entries, then flush them.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h2100;
    @(negedge clk);
    in_pc = 32'h2104;
    @(negedge clk);
    chk("fl_full", 32'(ifa.in_ready), 32'd0);
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", 32'(ifa.out_valid), 32'd0);
    chk("fl_rdy",   32'(ifa.in_ready),  32'd1);
    chk("fl_cnt",   cnt_b,              32'd14);
    send(32'h0050_0093, 32'h0000_3000);
    chk("fl_next_valid", 32'(ifa.out_valid), 32'd1);
    chk("fl_next_pc",    ifa.out_pc,         32'h3000);

    // Flush overrides a same-cycle accept but the completed handshake still counts.
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3004;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fa_valid", 32'(ifa.out_valid), 32'd0);
    chk("fa_cnt_b", cnt_b,              32'd15);
    chk("fa_cnt_a", 32'(cnt_a),         32'd15);

    send(32'h0050_0093, 32'h0000_3008);
    send(32'h0050_0093, 32'h0000_300C);
    chk("wr_pc", ifa.out_pc, 32'h300C);
    @(negedge clk);
    chk("wrap_cnt_a", 32'(cnt_a), 32'd1);
    chk("wrap_cnt_b", cnt_b,      32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
